// File: rtl/z80_mmu_decoder_if.sv
// rtl/z80_mmu_decoder_if.sv - CPU bus bundle between the tv80s core and the banked memory mapper
interface z80_mmu_decoder_if #(
  parameter int PHYS_W = 20,
  parameter int NUM_IO = 8
);
  logic              mreq_n;
  logic              ioreq_n;
  logic              rd_n;
  logic              wr_n;
  logic [15:0]       addr_i;
  logic [7:0]        data_i;
  logic [PHYS_W-1:0] phys_addr_o;
  logic              ram_cs;
  logic              rom_cs;
  logic [NUM_IO-1:0] io_cs;
  logic              mmu_cs;
  logic [7:0]        data_o;
  logic              wait_n;

  modport master (
    output mreq_n, ioreq_n, rd_n, wr_n, addr_i, data_i,
    input  phys_addr_o, ram_cs, rom_cs, io_cs, mmu_cs, data_o, wait_n
  );

  modport slave (
    input  mreq_n, ioreq_n, rd_n, wr_n, addr_i, data_i,
    output phys_addr_o, ram_cs, rom_cs, io_cs, mmu_cs, data_o, wait_n
  );
endinterface

// File: rtl/z80_mmu_decoder.sv
// rtl/z80_mmu_decoder.sv - banked memory mapper, boot-ROM overlay, I/O decoder and I/O wait generator
module z80_mmu_decoder #(
  parameter int         PAGE_BITS = 2,
  parameter int         PHYS_W    = 20,
  parameter int         ROM_BITS  = 13,
  parameter int         NUM_IO    = 8,
  parameter logic [7:0] MMU_BASE  = 8'hF0,
  parameter int         WAIT_IO   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  z80_mmu_decoder_if.slave bus
);
  localparam int         NUM_PAGES = 1 << PAGE_BITS;
  localparam int         PW        = PHYS_W - 16 + PAGE_BITS;
  localparam int         OFS_W     = 16 - PAGE_BITS;
  localparam logic [7:0] CTRL_OFS  = 8'(NUM_PAGES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [PW-1:0]        page_reg [NUM_PAGES];
  logic                 rom_en;
  logic [3:0]           wait_cnt;

  logic [1:0]           state;
  logic [3:0]           counter;
  logic                 wait_q;
  logic                 ioreq_q;

  logic [7:0]           port_ofs;
  logic                 mmu_hit;
  logic                 ctrl_hit;
  logic                 rom_hit;
  logic [PAGE_BITS-1:0] win;
  logic [PAGE_BITS-1:0] reg_idx;
  logic [NUM_IO-1:0]    io_sel;
  logic [7:0]           rd_byte;
  logic                 unused_rd;

  // The read strobe carries no information beyond ioreq/mreq with wr_n high.
  assign unused_rd = bus.rd_n;

  // Port offset from the register base; ports below the base wrap far above the window.
  assign port_ofs = bus.addr_i[7:0] - MMU_BASE;
  assign mmu_hit  = !bus.ioreq_n && (port_ofs <= CTRL_OFS);
  assign ctrl_hit = (port_ofs == CTRL_OFS);
  assign reg_idx  = port_ofs[PAGE_BITS-1:0];
  assign win      = bus.addr_i[15:OFS_W];

  // Logical-to-physical translation is always live; the chip selects qualify it.
  assign bus.phys_addr_o = {page_reg[win], bus.addr_i[OFS_W-1:0]};

  // Memory decode: the ROM overlay only claims reads, so writes fall through to RAM.
  always_comb begin
    rom_hit    = rom_en && (bus.addr_i[15:ROM_BITS] == '0) && bus.wr_n;
    bus.rom_cs = !bus.mreq_n && rom_hit;
    bus.ram_cs = !bus.mreq_n && !rom_hit;
  end

  // I/O decode: one 16-port block per device, starting at port 0x00.
  always_comb begin
    io_sel = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (!bus.ioreq_n && (bus.addr_i[7:4] == 4'(k))) io_sel[k] = 1'b1;
    end
  end

  assign bus.io_cs  = io_sel;
  assign bus.mmu_cs = mmu_hit;

  // Register read mux; idle bus reads as 0xFF like an undriven Z80 data bus.
  always_comb begin
    rd_byte = 8'hFF;
    if (mmu_hit) begin
      if (ctrl_hit) rd_byte = {3'b000, wait_cnt, rom_en};
      else          rd_byte = 8'(page_reg[reg_idx]);
    end
  end

  assign bus.data_o = rd_byte;

  // Page and control registers; every clock of a write access rewrites the same value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PAGES; i++) page_reg[i] <= PW'(i);
      rom_en   <= 1'b1;
      wait_cnt <= 4'(WAIT_IO);
    end else if (mmu_hit && !bus.wr_n) begin
      if (ctrl_hit) begin
        rom_en   <= bus.data_i[0];
        wait_cnt <= bus.data_i[4:1];
      end else begin
        page_reg[reg_idx] <= PW'(bus.data_i);
      end
    end
  end

  // Wait generator: starts on an ioreq_n falling sample, holds wait_n low wait_cnt clocks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      counter <= '0;
      wait_q  <= 1'b1;
      ioreq_q <= 1'b0;
    end else begin
      ioreq_q <= !bus.ioreq_n ? 1'b0 : 1'b1;
      case (state)
        ST_IDLE: begin
          wait_q <= 1'b1;
          if (!bus.ioreq_n && ioreq_q) begin
            counter <= wait_cnt;
            if (wait_cnt == 4'd0) begin
              state <= ST_HOLD;
            end else begin
              state  <= ST_WAIT;
              wait_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (bus.ioreq_n) begin
            state  <= ST_IDLE;
            wait_q <= 1'b1;
          end else if (counter == 4'd1) begin
            state  <= ST_HOLD;
            wait_q <= 1'b1;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        ST_HOLD: begin
          wait_q <= 1'b1;
          if (bus.ioreq_n) state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          wait_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wait_n = wait_q;
endmodule

// File: tb/tb_z80_mmu_decoder.sv
// tb/tb_z80_mmu_decoder.sv - self-checking bench for z80_mmu_decoder against a behavioural model
module tb_z80_mmu_decoder;
  localparam int PHYS_W = 20;
  localparam int NUM_IO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  z80_mmu_decoder_if #(.PHYS_W(PHYS_W), .NUM_IO(NUM_IO)) bus();

  z80_mmu_decoder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: four 16 KB windows, 6-bit page numbers, control at port 0xF4.
  int page_m [4];
  int rom_en_m;
  int wait_m;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) page_m[i] = i;
    rom_en_m = 1;
    wait_m   = 2;
  endfunction

  function automatic void model_io_write(int port, int data);
    if (port >= 'hF0 && port <= 'hF3) page_m[port - 'hF0] = data % 64;
    else if (port == 'hF4) begin
      rom_en_m = data % 2;
      wait_m   = (data / 2) % 16;
    end
  endfunction

  function automatic int model_phys(int addr);
    return page_m[addr / 16384] * 16384 + addr % 16384;
  endfunction

  function automatic int model_rd(int port);
    if (port >= 'hF0 && port <= 'hF3) return page_m[port - 'hF0];
    if (port == 'hF4) return wait_m * 2 + rom_en_m;
    return 255;
  endfunction

  function automatic int model_iocs(int port);
    if (port / 16 < NUM_IO) return 1 << (port / 16);
    return 0;
  endfunction

  task automatic idle_bus();
    bus.mreq_n  = 1'b1;
    bus.ioreq_n = 1'b1;
    bus.rd_n    = 1'b1;
    bus.wr_n    = 1'b1;
  endtask

  task automatic mem_drive(input int addr, input int wr);
    @(negedge clk);
    bus.addr_i = 16'(addr);
    bus.mreq_n = 1'b0;
    bus.wr_n   = wr ? 1'b0 : 1'b1;
    bus.rd_n   = wr ? 1'b1 : 1'b0;
    #1;
  endtask

  // Runs one full I/O access and reports the combinational view plus the wait_n profile.
  task automatic io_access(input int port, input int wr, input int data,
                           output int d_obs, output int cs_obs, output int mmu_obs,
                           output int lows, output int first, output int last);
    @(negedge clk);
    bus.addr_i  = {8'($urandom_range(0, 255)), 8'(port)};
    bus.data_i  = 8'(data);
    bus.ioreq_n = 1'b0;
    bus.wr_n    = wr ? 1'b0 : 1'b1;
    bus.rd_n    = wr ? 1'b1 : 1'b0;
    #1;
    d_obs   = int'(bus.data_o);
    cs_obs  = int'(bus.io_cs);
    mmu_obs = int'(bus.mmu_cs);
    lows = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.wait_n === 1'b0) begin
        lows++;
        if (first < 0) first = c;
        last = c;
      end
    end
    @(negedge clk);
    idle_bus();
  endtask

  task automatic test_reset();
    int d, cs, m, lo, fi, la;
    rst = 1'b1;
    idle_bus();
    bus.addr_i = 16'h0000;
    bus.data_i = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n got %0b expected 1", bus.wait_n); end
    checks++; if (bus.ram_cs !== 1'b0 || bus.rom_cs !== 1'b0) begin errors++; $display("FAIL reset_mem_cs got ram %0b rom %0b expected 0 0", bus.ram_cs, bus.rom_cs); end
    checks++; if (bus.io_cs !== 8'h00 || bus.mmu_cs !== 1'b0) begin errors++; $display("FAIL reset_io_cs got %0h mmu %0b expected 0 0", bus.io_cs, bus.mmu_cs); end
    checks++; if (bus.data_o !== 8'hFF) begin errors++; $display("FAIL reset_data_o got %0h expected ff", bus.data_o); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int p = 'hF0; p <= 'hF4; p++) begin
      io_access(p, 0, 0, d, cs, m, lo, fi, la);
      checks++; if (d !== model_rd(p) || m !== 1) begin errors++; $display("FAIL reset_reg_%0h got %0h mmu %0d expected %0h 1", p, d, m, model_rd(p)); end
    end
  endtask

  task automatic test_mem_and_io_basics();
    int d, cs, m, lo, fi, la;
    mem_drive('h0100, 0);
    checks++; if (bus.rom_cs !== 1'b1 || bus.ram_cs !== 1'b0) begin errors++; $display("FAIL rom_read got rom %0b ram %0b expected 1 0", bus.rom_cs, bus.ram_cs); end
    mem_drive('h0100, 1);
    checks++; if (bus.ram_cs !== 1'b1 || bus.rom_cs !== 1'b0 || bus.phys_addr_o !== 20'h00100) begin
      errors++; $display("FAIL rom_write got ram %0b rom %0b phys %0h expected 1 0 00100", bus.ram_cs, bus.rom_cs, bus.phys_addr_o); end
    @(negedge clk); idle_bus();
    io_access('hF2, 1, 'h2A, d, cs, m, lo, fi, la);
    model_io_write('hF2, 'h2A);
    mem_drive('h8123, 0);
    checks++; if (bus.phys_addr_o !== 20'hA8123 || bus.ram_cs !== 1'b1) begin errors++; $display("FAIL page2_map got %0h ram %0b expected a8123 1", bus.phys_addr_o, bus.ram_cs); end
    @(negedge clk); idle_bus();
    io_access('hF2, 0, 0, d, cs, m, lo, fi, la);
    checks++; if (d !== 'h2A || m !== 1) begin errors++; $display("FAIL page2_read got %0h mmu %0d expected 2a 1", d, m); end
    io_access('h13, 0, 0, d, cs, m, lo, fi, la);
    checks++; if (cs !== 'b0000_0010) begin errors++; $display("FAIL io_cs_13 got %0h expected 02", cs); end
    checks++; if (lo !== 2 || fi !== 0 || la !== 1) begin errors++; $display("FAIL wait_13 got lows %0d first %0d last %0d expected 2 0 1", lo, fi, la); end
    io_access('hA0, 0, 0, d, cs, m, lo, fi, la);
    checks++; if (cs !== 0 || d !== 'hFF || m !== 0) begin errors++; $display("FAIL port_a0 got cs %0h data %0h mmu %0d expected 0 ff 0", cs, d, m); end
  endtask

  task automatic test_rom_disable();
    int d, cs, m, lo, fi, la;
    io_access('hF4, 1, 'h00, d, cs, m, lo, fi, la);
    model_io_write('hF4, 'h00);
    mem_drive('h0000, 0);
    checks++; if (bus.ram_cs !== 1'b1 || bus.rom_cs !== 1'b0) begin errors++; $display("FAIL rom_off_read got ram %0b rom %0b expected 1 0", bus.ram_cs, bus.rom_cs); end
    @(negedge clk); idle_bus();
    io_access('h05, 0, 0, d, cs, m, lo, fi, la);
    checks++; if (lo !== 0) begin errors++; $display("FAIL zero_wait got lows %0d expected 0", lo); end
    io_access('hF4, 1, 'h05, d, cs, m, lo, fi, la);
    model_io_write('hF4, 'h05);
  endtask

  task automatic test_random();
    int d, cs, m, lo, fi, la, port, data, wr, addr, exp_wait, exp_rd, exp_rom;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        addr = $urandom_range(0, 65535);
        wr   = $urandom_range(0, 1);
        mem_drive(addr, wr);
        exp_rom = (rom_en_m == 1 && addr < 8192 && wr == 0) ? 1 : 0;
        checks++; if (bus.rom_cs !== 1'(exp_rom) || bus.ram_cs !== 1'(1 - exp_rom)) begin
          errors++; $display("FAIL rnd_mem_cs addr %0h got rom %0b ram %0b expected %0d %0d", addr, bus.rom_cs, bus.ram_cs, exp_rom, 1 - exp_rom); end
        checks++; if (bus.phys_addr_o !== 20'(model_phys(addr))) begin
          errors++; $display("FAIL rnd_phys addr %0h got %0h expected %0h", addr, bus.phys_addr_o, model_phys(addr)); end
        @(negedge clk); idle_bus();
      end else begin
        port = ($urandom_range(0, 1) == 0) ? $urandom_range('hF0, 'hF4) : $urandom_range(0, 255);
        wr   = $urandom_range(0, 1);
        data = $urandom_range(0, 255);
        if (port == 'hF4 && wr == 1) data = data % 32;
        exp_wait = wait_m;
        exp_rd   = model_rd(port);
        io_access(port, wr, data, d, cs, m, lo, fi, la);
        if (wr == 1) model_io_write(port, data);
        checks++; if (cs !== model_iocs(port) || d !== exp_rd || m !== ((port >= 'hF0 && port <= 'hF4) ? 1 : 0)) begin
          errors++; $display("FAIL rnd_io port %0h got cs %0h data %0h mmu %0d expected cs %0h data %0h", port, cs, d, m, model_iocs(port), exp_rd); end
        checks++; if (lo !== exp_wait || (exp_wait > 0 && (fi !== 0 || la !== exp_wait - 1))) begin
          errors++; $display("FAIL rnd_wait port %0h got lows %0d first %0d expected %0d", port, lo, fi, exp_wait); end
      end
    end
    io_access('hF4, 1, 'h05, d, cs, m, lo, fi, la);
    model_io_write('hF4, 'h05);
    for (int p = 0; p < 4; p++) begin
      io_access('hF0 + p, 1, p, d, cs, m, lo, fi, la);
      model_io_write('hF0 + p, p);
    end
  endtask

  task automatic test_reset_mid_wait();
    int d, cs, m, lo, fi, la, lows;
    io_access('hF3, 1, 'h3F, d, cs, m, lo, fi, la);
    model_io_write('hF3, 'h3F);
    @(negedge clk);
    bus.addr_i = 16'h00F3; bus.ioreq_n = 1'b0; bus.rd_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.wait_n !== 1'b0) begin errors++; $display("FAIL pre_rst_wait got %0b expected 0", bus.wait_n); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait got %0b expected 1", bus.wait_n); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    lows = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.wait_n === 1'b0) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL held_ioreq_no_wait got lows %0d expected 0", lows); end
    checks++; if (bus.data_o !== 8'(model_rd('hF3))) begin errors++; $display("FAIL rst_page3 got %0h expected %0h", bus.data_o, model_rd('hF3)); end
    bus.addr_i = 16'h00F4; #1;
    checks++; if (bus.data_o !== 8'(model_rd('hF4))) begin errors++; $display("FAIL rst_ctrl got %0h expected %0h", bus.data_o, model_rd('hF4)); end
    @(negedge clk); idle_bus();
  endtask

  task automatic test_abort();
    int d, cs, m, lo, fi, la;
    @(negedge clk);
    bus.addr_i = 16'h0013; bus.ioreq_n = 1'b0; bus.rd_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.wait_n !== 1'b0) begin errors++; $display("FAIL abort_first got %0b expected 0", bus.wait_n); end
    @(negedge clk); idle_bus();
    @(posedge clk); #1;
    checks++; if (bus.wait_n !== 1'b1) begin errors++; $display("FAIL abort_release got %0b expected 1", bus.wait_n); end
    io_access('h13, 0, 0, d, cs, m, lo, fi, la);
    checks++; if (lo !== wait_m || fi !== 0) begin errors++; $display("FAIL after_abort got lows %0d first %0d expected %0d 0", lo, fi, wait_m); end
  endtask

  task automatic test_back_to_back();
    int d, cs, m, lo, fi, la;
    for (int n = 0; n < 4; n++) begin
      io_access($urandom_range(0, 127), 0, 0, d, cs, m, lo, fi, la);
      checks++; if (lo !== wait_m || fi !== 0 || la !== wait_m - 1) begin
        errors++; $display("FAIL b2b_%0d got lows %0d first %0d last %0d expected %0d", n, lo, fi, la, wait_m); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    idle_bus();
    bus.addr_i = 16'h0000;
    bus.data_i = 8'h00;
    model_reset();
    test_reset();
    test_mem_and_io_basics();
    test_rom_disable();
    test_random();
    test_reset_mid_wait();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z80_mmu_decoder.md
Name: z80_mmu_decoder

Overview:
- Parametrised successor to the fixed Z80 address decoder: banked memory mapper plus I/O decoder on the tv80s bus.
- Splits the 64 KB logical space into 2^PAGE_BITS windows, each mapped through a page register onto a PHYS_W-bit physical RAM address.
- Provides a removable boot-ROM overlay, NUM_IO one-hot I/O chip selects and a programmable I/O wait-state generator.
- Sits between the CPU and the RAM, ROM, UART and LED blocks. The top-level read mux uses its chip selects.

Parameters:
- PAGE_BITS, 2, log2 of window count; window size is 2^(16-PAGE_BITS) bytes
- PHYS_W, 20, physical RAM address width; must exceed 16-PAGE_BITS
- ROM_BITS, 13, boot-ROM overlay size 2^ROM_BITS bytes at logical 0x0000
- NUM_IO, 8, number of I/O chip selects, 16 ports each, starting at port 0x00; max 15
- MMU_BASE, 8'hF0, I/O port of page register 0; control register at MMU_BASE+2^PAGE_BITS
- WAIT_IO, 2, wait cycles inserted per I/O access, 0..15

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active high
- mreq_n  in  1  CPU memory request
- ioreq_n  in  1  CPU I/O request
- rd_n  in  1  CPU read strobe
- wr_n  in  1  CPU write strobe
- addr_i  in  16  CPU address
- data_i  in  8  CPU write data
- phys_addr_o  out  PHYS_W  translated RAM address
- ram_cs  out  1  RAM select
- rom_cs  out  1  boot-ROM select
- io_cs  out  NUM_IO  one-hot I/O device selects
- mmu_cs  out  1  this block's registers are addressed; the top mux takes data_o
- data_o  out  8  register read data
- wait_n  out  1  CPU wait, active low

Behaviour:
- Page registers: page_reg[i], PHYS_W-16+PAGE_BITS bits wide. Reset value is i, giving an identity map of the low 64 KB.
- Control register: bit0 rom_en (reset 1); bits 4:1 wait_cnt (reset WAIT_IO); other bits read 0.
- Translation (combinational): phys_addr_o = {page_reg[addr_i[15:16-PAGE_BITS]], addr_i[15-PAGE_BITS:0]}.
- Memory decode (combinational, only when mreq_n=0):
  - rom_cs=1 when rom_en=1, addr_i[15:ROM_BITS]==0 and wr_n=1.
  - ram_cs=1 otherwise. Writes into the ROM region land in RAM underneath.
- I/O decode (combinational, only when ioreq_n=0, uses addr_i[7:0]):
  - io_cs[k]=1 when addr_i[7:4]==k and k<NUM_IO.
  - mmu_cs=1 for MMU_BASE..MMU_BASE+2^PAGE_BITS.
  - Any other port selects nothing; the top mux then sees data_o=8'hFF.
- Register write: occurs on every rising clk_i where ioreq_n=0, wr_n=0 and the register is addressed. Repeated cycles in one access rewrite the same value. Unused upper data bits are ignored.
- Read data:
  - data_o is combinational from addr_i[7:0]: zero-extended page_reg or control.
  - data_o=8'hFF when mmu_cs=0.
- Wait generator FSM:
  - States: IDLE, WAIT, HOLD.
  - IDLE -> WAIT on the first clock with ioreq_n=0 after a clock with ioreq_n=1; load counter=wait_cnt.
  - If wait_cnt==0, go IDLE -> HOLD directly; no wait is inserted.
  - WAIT: wait_n=0, counter decrements each clock; at 1 go to HOLD.
  - HOLD: wait_n=1 until ioreq_n=1, then IDLE.
  - If ioreq_n deasserts during WAIT (abort), go to IDLE with wait_n=1 next clock.
  - wait_n is registered: low for exactly wait_cnt consecutive cycles, starting the cycle after the ioreq_n falling sample.
  - Memory cycles never wait.
- Reset:
  - rst_i mid-operation restores all registers, sets FSM to IDLE and wait_n=1 on the next edge.
  - An ioreq_n already low when reset releases does not start a wait sequence; an ioreq_n high->low transition is required.
  - Combinational outputs follow their inputs using the reset register values.

Test Plan:
- After reset, memory read 0x0100 -> rom_cs=1, ram_cs=0. Memory write 0x0100 -> ram_cs=1, phys_addr_o=0x00100.
- OUT (0xF2),0x2A, then memory read 0x8123 -> phys_addr_o=0xA8123. IN (0xF2) -> data_o=0x2A, mmu_cs=1.
- OUT (0xF4),0x00 -> rom_en=0 and wait_cnt=0. Read 0x0000 -> ram_cs=1, rom_cs=0. Next I/O access has wait_n held at 1.
- IN (0x13) with reset config -> io_cs=8'b0000_0010 and wait_n low for exactly 2 cycles. IN (0xA0) -> io_cs=0, data_o=0xFF.
- Assert rst_i during the WAIT state with page_reg[3]=0x3F -> next edge wait_n=1, page_reg[3]=3, rom_en=1.
- ioreq_n released after 1 of 2 wait cycles -> FSM returns to IDLE. The following I/O access again inserts 2 wait cycles.
